// File: rtl/text_rom_pkg.sv
// Shared constants for the text ROM arbiter: default geometry and owner-state encoding.
package text_rom_pkg;

  localparam int DEF_ADDR_W    = 14;
  localparam int DEF_DATA_W    = 2;
  localparam int DEF_MAX_BURST = 16;

  // Owner state: IDLE means nobody holds a lock, OWNn means requester n keeps the ROM.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

endpackage

// File: rtl/text_rom_arbiter_if.sv
// Bundle of requester, ROM and response signals shared between the arbiter and its clients.
interface text_rom_arbiter_if
  import text_rom_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic              lock0;
  logic              lock1;
  logic              gnt0;
  logic              gnt1;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              rsp_valid;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;

  // Client side: requesters plus the ROM that answers rom_addr.
  modport master (
    output req0, req1, addr0, addr1, lock0, lock1, rom_data,
    input  gnt0, gnt1, rom_addr, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req0, req1, addr0, addr1, lock0, lock1, rom_data,
    output gnt0, gnt1, rom_addr, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/text_rom_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the favoured side.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       prio_i,   // 0 favours requester 0, 1 favours requester 1
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = prio_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/text_rom_arbiter.sv
// Arbitrates two glyph fetchers onto one synchronous-read ROM with lockable bursts.
module text_rom_arbiter
  import text_rom_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input logic               Clk,
  input logic               Reset,
  text_rom_arbiter_if.slave bus
);

  localparam int              CNT_W   = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [1:0]        rr_gnt;
  logic [1:0]        gnt;
  logic              gnt_any;
  logic              gnt_lock;

  rr_pick2 u_pick (
    .req_i  ({bus.req1, bus.req0}),
    .prio_i (ptr_q),
    .gnt_o  (rr_gnt)
  );

  // Owner keeps the ROM while it requests; grants are suppressed for the whole reset pulse.
  always_comb begin
    case (state_q)
      ST_OWN0: gnt = {1'b0, bus.req0};
      ST_OWN1: gnt = {bus.req1, 1'b0};
      default: gnt = rr_gnt;
    endcase
    if (Reset) begin
      gnt = 2'b00;
    end
  end

  assign gnt_any  = |gnt;
  assign gnt_lock = gnt[1] ? bus.lock1 : bus.lock0;

  always_comb begin
    state_d     = ST_IDLE;
    cnt_d       = '0;
    ptr_d       = ptr_q;
    addr_d      = addr_q;
    rsp_valid_d = gnt_any;
    rsp_id_d    = gnt[1];
    if (gnt_any) begin
      // Point at whoever was not just served; this also hands over after a forced release.
      ptr_d  = gnt[0];
      addr_d = gnt[1] ? bus.addr1 : bus.addr0;
      cnt_d  = (state_q == ST_IDLE) ? CNT_ONE : cnt_q + CNT_ONE;
      if (gnt_lock && (cnt_d < CNT_MAX)) begin
        state_d = gnt[1] ? ST_OWN1 : ST_OWN0;
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ptr_q       <= 1'b0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign bus.gnt0      = gnt[0];
  assign bus.gnt1      = gnt[1];
  assign bus.rom_addr  = addr_d;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = bus.rom_data;

endmodule

// File: doc/text_rom_arbiter.md
TEXT_ROM_ARBITER -- requirements
Module: text_rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning ROM address width.
REQ-002 SHALL have parameter DATA_W, default 2, meaning ROM data width.
REQ-003 SHALL have parameter MAX_BURST, default 16, meaning maximum consecutive grants under lock.
REQ-004 SHALL have port Clk  input  1  the single clock; all state changes on rising edge.
REQ-005 SHALL have port Reset  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have ports req0, req1  input  1 each  read request from requester 0 / 1.
REQ-007 SHALL have ports addr0, addr1  input  ADDR_W each  read address from requester 0 / 1.
REQ-008 SHALL have ports lock0, lock1  input  1 each  request to keep the grant on the next cycle (glyph burst).
REQ-009 SHALL have ports gnt0, gnt1  output  1 each  combinational grant this cycle.
REQ-010 SHALL have port rom_addr  output  ADDR_W  address to the synchronous-read ROM.
REQ-011 SHALL have port rom_data  input  DATA_W  ROM output, valid one cycle after its address.
REQ-012 SHALL have ports rsp_valid  output  1, rsp_id  output  1, rsp_data  output  DATA_W  returned read.

Function
REQ-013 SHALL assert at most one of gnt0/gnt1 per cycle; gntN only when reqN=1.
REQ-014 SHALL drive rom_addr = addr of the granted requester, else hold the last granted address.
REQ-015 SHALL use states IDLE, OWN0, OWN1 (registered owner); IDLE = no lock held.
REQ-016 In IDLE, a sole requester SHALL be granted; on simultaneous req0/req1, grant goes to the requester not served last (round-robin pointer, reset value favours requester 0).
REQ-017 On a grant to N with lockN=1, next state SHALL be OWNN and the burst counter SHALL load 1; otherwise state stays IDLE.
REQ-018 In OWNN, reqN=1 SHALL be granted regardless of the other requester; the counter increments per grant.
REQ-019 In OWNN, transition to IDLE SHALL occur after the grant in which lockN=0, reqN=0 (no grant that cycle, arbitration resumes in IDLE next cycle), or the counter reaches MAX_BURST.
REQ-020 On forced release at MAX_BURST, the round-robin pointer SHALL favour the other requester so a waiting requester is granted next cycle.
REQ-021 Latency: grant in cycle N SHALL yield rsp_valid=1 in cycle N+1 with rsp_id = granted index and rsp_data = rom_data (pass-through).
REQ-022 rsp_valid SHALL be 0 in any cycle following a cycle with no grant; back-to-back grants SHALL give back-to-back responses (throughput 1/cycle).
REQ-023 Counter width SHALL be $clog2(MAX_BURST)+1; no wrap is permitted (release precedes overflow).
REQ-024 Requester address changes while not granted SHALL have no effect.

Reset
REQ-025 Reset SHALL force state IDLE, counter 0, pointer favouring requester 0, rsp_valid 0, rsp_id 0, held rom_addr 0.
REQ-026 Reset mid-burst SHALL drop the ownership and discard any in-flight response (no rsp_valid after reset deassertion until a new grant).
REQ-027 gnt0/gnt1 SHALL be 0 while Reset is asserted.

Structure
REQ-028 State enum (IDLE/OWN0/OWN1) and default ADDR_W/DATA_W/MAX_BURST constants SHALL live in shared package text_rom_pkg.
REQ-029 A single sub-module rr_pick2 (2-way round-robin priority pick) SHALL be used; the ROM itself is instantiated outside this block.

Verification
REQ-030 Only req0 with addr0=0x0100, no lock -> gnt0=1, rom_addr=0x0100; next cycle rsp_valid=1, rsp_id=0, rsp_data=mem[0x0100].
REQ-031 req0 and req1 both held 4 cycles, no lock, after reset -> grants 0,1,0,1; responses ids 0,1,0,1 one cycle later.
REQ-032 lock0=1, req0 held 20 cycles, req1 held -> 16 consecutive gnt0, then gnt1 on cycle 17.
REQ-033 lock1 burst of 5 then lock1=0 on 5th grant, req0 pending -> gnt0 on cycle 6.
REQ-034 Reset asserted asynchronously during OWN0 grant 3 -> gnt0 drops immediately; no rsp_valid cycle after release; state IDLE.
REQ-035 Neither request for 3 cycles -> gnt0=gnt1=0, rsp_valid=0, rom_addr holds last value.
